// File: rtl/stos_pkg.sv
// Shared types and constants for the return-address stack (stos_powrotu).
// Optional feature macro: STOS_BLAD_EN (sticky error flag and code).
package stos_pkg;

  // Default frame width; matches the default PC width.
  localparam int STOS_W = 8;

  // One stack frame: interrupt tag plus the stored return address.
  typedef struct packed {
    logic              tag;
    logic [STOS_W-1:0] adres;
  } ramka_t;

  // Error causes, first one wins.
  localparam logic [1:0] BLAD_BRAK          = 2'b00;
  localparam logic [1:0] BLAD_PRZEPELNIENIE = 2'b01;
  localparam logic [1:0] BLAD_NIEDOMIAR     = 2'b10;
  localparam logic [1:0] BLAD_NIEZGODNOSC   = 2'b11;

  // A RETI must pop an interrupt frame and a RET must pop a call frame.
  function automatic logic niezgodnosc(input logic tag, input logic reti);
    return tag != reti;
  endfunction

endpackage

// File: rtl/stos_pamiec.sv
// Below-top storage of the return stack: GLEB-1 entries of {tag, adres},
// synchronous write, asynchronous read.
module stos_pamiec #(
  parameter int W    = 8,
  parameter int GLEB = 8
) (
  input  logic                                           clk,
  input  logic                                           we,
  input  logic [((GLEB-1) > 1 ? $clog2(GLEB-1) : 1)-1:0] waddr,
  input  logic [W:0]                                     wdata,
  input  logic [((GLEB-1) > 1 ? $clog2(GLEB-1) : 1)-1:0] raddr,
  output logic [W:0]                                     rdata
);

  localparam int GL = GLEB - 1;

  logic [W:0] mem [GL];

  // Write port: the old top sinks into the array on a push.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/stos_powrotu.sv
// Hardware return-address stack feeding the PC stack-jump input.
// Top entry lives in flops so the PC can use it in the same cycle as the
// return decode. Optional macro STOS_BLAD_EN adds blad/blad_kod.
module stos_powrotu
  import stos_pkg::*;
#(
  parameter int W    = 8,
  parameter int GLEB = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ID_rst,
  input  logic                      push_call,
  input  logic                      push_int,
  input  logic [W-1:0]              adres_powrotu,
  input  logic                      pop_ret,
  input  logic                      pop_reti,
  output logic [W-1:0]              adres_skok_pc_stos,
  output logic                      ramka_int,
  output logic                      pusty,
  output logic                      pelny,
  output logic [$clog2(GLEB+1)-1:0] wskaznik
`ifdef STOS_BLAD_EN
  ,
  output logic                      blad,
  output logic [1:0]                blad_kod
`endif
);

  localparam int CW = $clog2(GLEB + 1);
  localparam int AW = (GLEB - 1) > 1 ? $clog2(GLEB - 1) : 1;

  logic [CW-1:0] cnt;
  logic          tos_tag;
  logic [W-1:0]  tos_adres;

  // Interrupt push dominates a simultaneous call push; RETI dominates RET.
  logic push, pop, reti, nowy_tag, empty, full;
  assign push     = push_call | push_int;
  assign nowy_tag = push_int;
  assign pop      = pop_ret | pop_reti;
  assign reti     = pop_reti;
  assign empty    = (cnt == '0);
  assign full     = (cnt == CW'(GLEB));

  logic          mem_we;
  logic [AW-1:0] mem_waddr, mem_raddr;
  logic [W:0]    mem_rd;

  // Only a plain push on a non-empty, non-full stack moves the old top down.
  assign mem_we    = push && !pop && !full && !empty;
  assign mem_waddr = empty ? '0 : AW'(cnt - CW'(1));
  assign mem_raddr = (cnt >= CW'(2)) ? AW'(cnt - CW'(2)) : '0;

  stos_pamiec #(.W(W), .GLEB(GLEB)) u_pamiec (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata ({tos_tag, tos_adres}),
    .raddr (mem_raddr),
    .rdata (mem_rd)
  );

  // Pointer and top-of-stack update: replace-top, push, or pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      tos_tag   <= 1'b0;
      tos_adres <= '0;
    end else if (ID_rst) begin
      cnt       <= '0;
      tos_tag   <= 1'b0;
      tos_adres <= '0;
    end else if (push && pop && !empty) begin
      tos_tag   <= nowy_tag;
      tos_adres <= adres_powrotu;
    end else if (push) begin
      if (!full) begin
        tos_tag   <= nowy_tag;
        tos_adres <= adres_powrotu;
        cnt       <= cnt + CW'(1);
      end
    end else if (pop && !empty) begin
      if (cnt >= CW'(2)) begin
        tos_tag   <= mem_rd[W];
        tos_adres <= mem_rd[W-1:0];
      end else begin
        tos_tag   <= 1'b0;
        tos_adres <= '0;
      end
      cnt <= cnt - CW'(1);
    end
  end

`ifdef STOS_BLAD_EN
  logic przepelnienie, niedomiar, zla_ramka;
  assign przepelnienie = push && !pop && full;
  assign niedomiar     = pop && !push && empty;
  assign zla_ramka     = pop && !empty && niezgodnosc(tos_tag, reti);

  // Sticky first-error capture; later errors leave the code alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blad     <= 1'b0;
      blad_kod <= BLAD_BRAK;
    end else if (ID_rst) begin
      blad     <= 1'b0;
      blad_kod <= BLAD_BRAK;
    end else if (!blad) begin
      if (przepelnienie) begin
        blad     <= 1'b1;
        blad_kod <= BLAD_PRZEPELNIENIE;
      end else if (niedomiar) begin
        blad     <= 1'b1;
        blad_kod <= BLAD_NIEDOMIAR;
      end else if (zla_ramka) begin
        blad     <= 1'b1;
        blad_kod <= BLAD_NIEZGODNOSC;
      end
    end
  end
`endif

  assign adres_skok_pc_stos = tos_adres;
  assign ramka_int          = tos_tag;
  assign pusty              = empty;
  assign pelny              = full;
  assign wskaznik           = cnt;

endmodule

// File: tb/tb_stos_powrotu.sv
// Bench for stos_powrotu: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a queue-based stack model.
module tb_stos_powrotu;

  localparam int W    = 8;
  localparam int GLEB = 8;
  localparam int CW   = $clog2(GLEB + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ID_rst = 1'b0;
  logic          push_call = 1'b0, push_int = 1'b0;
  logic [W-1:0]  adres_powrotu = '0;
  logic          pop_ret = 1'b0, pop_reti = 1'b0;
  logic [W-1:0]  adres_skok_pc_stos;
  logic          ramka_int, pusty, pelny;
  logic [CW-1:0] wskaznik;
`ifdef STOS_BLAD_EN
  logic          blad;
  logic [1:0]    blad_kod;
`endif

  int vectors = 0;
  int miscompares = 0;

  stos_powrotu #(.W(W), .GLEB(GLEB)) dut (
    .clk                (clk),
    .rst                (rst),
    .ID_rst             (ID_rst),
    .push_call          (push_call),
    .push_int           (push_int),
    .adres_powrotu      (adres_powrotu),
    .pop_ret            (pop_ret),
    .pop_reti           (pop_reti),
    .adres_skok_pc_stos (adres_skok_pc_stos),
    .ramka_int          (ramka_int),
    .pusty              (pusty),
    .pelny              (pelny),
    .wskaznik           (wskaznik)
`ifdef STOS_BLAD_EN
    ,
    .blad               (blad),
    .blad_kod           (blad_kod)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of {tag, adres}, back of queue is the top.
  logic [W:0] q[$];
  logic       m_blad;
  logic [1:0] m_kod;

  function automatic void m_err(input logic [1:0] k);
    if (!m_blad) begin
      m_blad = 1'b1;
      m_kod  = k;
    end
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst || ID_rst) begin
      q.delete();
      m_blad = 1'b0;
      m_kod  = 2'b00;
    end else begin
      logic ps, pp, rt;
      ps = push_call | push_int;
      pp = pop_ret | pop_reti;
      rt = pop_reti;
      if (ps && pp && q.size() > 0) begin
        if (q[q.size()-1][W] != rt) m_err(2'b11);
        q[q.size()-1] = {push_int, adres_powrotu};
      end else if (ps) begin
        if (q.size() == GLEB) m_err(2'b01);
        else q.push_back({push_int, adres_powrotu});
      end else if (pp) begin
        if (q.size() == 0) m_err(2'b10);
        else begin
          if (q[q.size()-1][W] != rt) m_err(2'b11);
          void'(q.pop_back());
        end
      end
    end
  end

  // Every-cycle comparison of outputs against the model, mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      logic [W:0] top;
      top = (q.size() > 0) ? q[q.size()-1] : '0;
      chk("adres", 32'(adres_skok_pc_stos), 32'(top[W-1:0]));
      chk("ramka_int", 32'(ramka_int), 32'(top[W]));
      chk("wskaznik", 32'(wskaznik), 32'(q.size()));
      chk("pusty", 32'(pusty), 32'(q.size() == 0));
      chk("pelny", 32'(pelny), 32'(q.size() == GLEB));
`ifdef STOS_BLAD_EN
      chk("blad", 32'(blad), 32'(m_blad));
      chk("blad_kod", 32'(blad_kod), 32'(m_kod));
`endif
    end
  end

  // One clock of stimulus; returns 1 time unit after the edge.
  task automatic apply(input logic pc, input logic pi, input logic [W-1:0] a,
                       input logic pr, input logic pri, input logic ir);
    push_call = pc; push_int = pi; adres_powrotu = a;
    pop_ret = pr; pop_reti = pri; ID_rst = ir;
    @(posedge clk); #1;
    push_call = 0; push_int = 0; pop_ret = 0; pop_reti = 0; ID_rst = 0;
  endtask

  task automatic lit(input string nm, input logic [W-1:0] a, input logic t,
                     input int n, input logic pu, input logic pe);
    chk({nm, ".adres"}, 32'(adres_skok_pc_stos), 32'(a));
    chk({nm, ".ramka"}, 32'(ramka_int), 32'(t));
    chk({nm, ".wsk"}, 32'(wskaznik), 32'(n));
    chk({nm, ".pusty"}, 32'(pusty), 32'(pu));
    chk({nm, ".pelny"}, 32'(pelny), 32'(pe));
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    lit("reset", 8'h00, 0, 0, 1, 0);
`ifdef STOS_BLAD_EN
    chk("reset.blad", 32'(blad), 0);
    chk("reset.kod", 32'(blad_kod), 0);
`endif
    rst = 1'b0;

    // Single call push
    apply(1, 0, 8'h10, 0, 0, 0);
    lit("push1", 8'h10, 0, 1, 0, 0);

    // Interrupt frame on top, then RETI
    apply(0, 1, 8'h22, 0, 0, 0);
    lit("popcyc", 8'h22, 1, 2, 0, 0);
    apply(0, 0, 8'h00, 0, 1, 0);
    lit("afterreti", 8'h10, 0, 1, 0, 0);
    apply(0, 0, 8'h00, 1, 0, 0);
    lit("drain", 8'h00, 0, 0, 1, 0);

    // Fill, overflow, drain in order
    for (int i = 1; i <= GLEB; i++) apply(1, 0, W'(i), 0, 0, 0);
    apply(1, 0, 8'hFF, 0, 0, 0);
    lit("full", 8'h08, 0, 8, 0, 1);
`ifdef STOS_BLAD_EN
    chk("ovf.blad", 32'(blad), 1);
    chk("ovf.kod", 32'(blad_kod), 32'h1);
`endif
    for (int i = GLEB; i >= 1; i--) begin
      chk("drain.seq", 32'(adres_skok_pc_stos), 32'(i));
      apply(0, 0, 8'h00, 1, 0, 0);
    end
    lit("empty", 8'h00, 0, 0, 1, 0);

    // Underflow, then a push keeps the first code
    apply(0, 0, 8'h00, 0, 0, 1);
    apply(0, 0, 8'h00, 1, 0, 0);
    lit("undf", 8'h00, 0, 0, 1, 0);
`ifdef STOS_BLAD_EN
    chk("undf.kod", 32'(blad_kod), 32'h2);
`endif
    apply(1, 0, 8'h33, 0, 0, 0);
    lit("after_undf", 8'h33, 0, 1, 0, 0);
`ifdef STOS_BLAD_EN
    chk("after_undf.kod", 32'(blad_kod), 32'h2);
`endif

    // Replace-top
    apply(0, 0, 8'h00, 0, 0, 1);
    apply(1, 0, 8'h10, 0, 0, 0);
    apply(1, 0, 8'h20, 0, 0, 0);
    apply(1, 0, 8'h40, 1, 0, 0);
    lit("replace", 8'h40, 0, 2, 0, 0);
    apply(0, 0, 8'h00, 1, 0, 0);
    lit("replace.pop", 8'h10, 0, 1, 0, 0);

    // Asynchronous reset mid-cycle with 3 entries
    apply(1, 0, 8'h50, 0, 0, 0);
    apply(1, 0, 8'h60, 0, 0, 0);
    lit("three", 8'h60, 0, 3, 0, 0);
    #2 rst = 1'b1;
    #1;
    lit("async_rst", 8'h00, 0, 0, 1, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Synchronous ID_rst with 3 entries
    apply(0, 1, 8'h71, 0, 0, 0);
    apply(1, 0, 8'h72, 0, 0, 0);
    apply(1, 0, 8'h73, 0, 0, 0);
    lit("three_b", 8'h73, 0, 3, 0, 0);
    apply(0, 0, 8'h00, 0, 0, 1);
    lit("id_rst", 8'h00, 0, 0, 1, 0);

    // Randomized traffic, checked by the per-cycle compare process
    for (int n = 0; n < 3000; n++) begin
      int r;
      logic pc, pi, pr, pri, ir;
      r   = int'($urandom_range(0, 99));
      pc  = (r < 40) || (r >= 90 && r < 95);
      pi  = (r >= 30 && r < 50) || (r >= 93 && r < 97);
      pr  = (r >= 50 && r < 75) || (r >= 90 && r < 92);
      pri = (r >= 70 && r < 90) || (r >= 94 && r < 96);
      ir  = ($urandom_range(0, 199) == 0);
      apply(pc, pi, W'($urandom), pr, pri, ir);
    end

    @(negedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/stos_powrotu.md
# stos_powrotu

Hardware return-address stack that feeds the program counter's stack jump input. On CALL it stores the caller's PC. On interrupt entry it stores the interrupted PC and tags that entry as an interrupt frame. On RET/RETI it pops. The top-of-stack address and frame tag are always presented from flops, so the PC can consume them in the same cycle that the decoder asserts the return.

## Interface
Parameters:
- W, 8, address width; matches the PC width.
- GLEB, 8, total stack depth in entries (≥2); includes the top-of-stack register.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- ID_rst  in  1  synchronous clear from the decoder; same effect as rst, applied on the next edge.
- push_call  in  1  push `adres_powrotu` as a call frame (tag 0).
- push_int  in  1  push `adres_powrotu` as an interrupt frame (tag 1).
- adres_powrotu  in  W  address to store: the CALL's own address, or the interrupted address.
- pop_ret  in  1  pop the top entry (RET).
- pop_reti  in  1  pop the top entry (RETI).
- adres_skok_pc_stos  out  W  address field of the top entry; 0 when empty.
- ramka_int  out  1  tag of the top entry; PC uses it to suppress the +1; 0 when empty.
- pusty  out  1  stack holds 0 entries.
- pelny  out  1  stack holds GLEB entries.
- wskaznik  out  $clog2(GLEB+1)  current entry count.
- blad  out  1  sticky error flag; present only with STOS_BLAD_EN.
- blad_kod  out  2  first error cause; present only with STOS_BLAD_EN.

## Operation
- Storage is split into two parts:
  - a top register `tos` holding {tag, address};
  - a memory of GLEB-1 entries holding everything below the top.
- The count is held in `wskaznik`.
- Push resolution: if push_int and push_call are both high, only the interrupt frame is pushed.
- Pop resolution: if pop_ret and pop_reti are both high, the pop is treated as RETI.
- Push, not full:
  - the current tos moves to memory at index wskaznik-1 (only when wskaznik>0);
  - tos takes {tag, adres_powrotu};
  - wskaznik increments.
- Pop, not empty:
  - tos takes memory[wskaznik-2] when wskaznik≥2; otherwise tos is cleared to 0;
  - wskaznik decrements.
- Push and pop in the same cycle:
  - not empty: replace-top. tos is overwritten with the new entry and wskaznik is unchanged.
  - empty: the pop is ignored and the push proceeds.
- Push when full: ignored, no state change. Records an overflow error (code 2'b01).
- Pop when empty: ignored. Outputs stay 0. Records an underflow error (code 2'b10).
- Arithmetic: `wskaznik` never wraps; it saturates at 0 and at GLEB by the rules above. Addresses are stored unmodified. The +1 for CALL returns is the PC's responsibility.

## Timing
- Reset values (on rst, asynchronously, and on ID_rst, at the next edge): tos=0, wskaznik=0, pusty=1, pelny=0, adres_skok_pc_stos=0, ramka_int=0, blad=0, blad_kod=0. Memory contents are don't-care.
- A push at edge N makes the new address visible on adres_skok_pc_stos after edge N, i.e. in cycle N+1.
- Return path: the decoder asserts pop_ret/pop_reti in cycle N. The PC samples adres_skok_pc_stos in that same cycle N (no combinational path from the pop inputs). The next entry surfaces in cycle N+1.
- pusty, pelny and wskaznik are registered-derived and change only on edges.
- Back-to-back push/pop on consecutive cycles is supported at full rate, with no bubbles.
- rst asserted mid-operation clears all state immediately. The outputs are valid 0 before the next edge.

## Configuration
- `STOS_BLAD_EN` defined:
  - `blad` and `blad_kod` exist.
  - The first error latches `blad=1` and its code. Later errors do not change the code. Only rst/ID_rst clear the flag.
  - Mismatch detection is active:
    - pop_ret alone popping a tag-1 entry gives code 2'b11;
    - pop_reti popping a tag-0 entry gives code 2'b11.
  - A mismatched pop is still performed.
- `STOS_BLAD_EN` undefined: the ports and error logic are absent. Errored operations are silently ignored as described in Operation.

## Structure
- Shared package `stos_pkg`:
  - typedef `ramka_t` = packed struct {logic tag; logic [W-1:0] adres};
  - error-code constants BLAD_BRAK=2'b00, BLAD_PRZEPELNIENIE=2'b01, BLAD_NIEDOMIAR=2'b10, BLAD_NIEZGODNOSC=2'b11.
- One sub-module, `stos_pamiec`:
  - GLEB-1 deep, synchronous write, asynchronous read;
  - holds the below-top entries.
- Pointer control and tos live in stos_powrotu.

## Test plan
- Reset, then push_call with adres 8'h10 -> next cycle adres_skok_pc_stos=8'h10, ramka_int=0, wskaznik=1, pusty=0.
- push_call 8'h10, push_int 8'h22, then pop_reti -> the pop cycle shows 8'h22 with ramka_int=1; the following cycle shows 8'h10 with ramka_int=0.
- Fill all GLEB=8 entries with 8'h01..8'h08, then push 8'hFF -> pelny=1, top stays 8'h08, blad=1, blad_kod=01. Eight pops then return 08..01 in order and end with pusty=1.
- Pop from empty -> outputs stay 0, wskaznik=0, blad_kod=10. Then push 8'h33 -> top=8'h33 and the code stays 10.
- With 2 entries {8'h10, 8'h20}, assert push_call 8'h40 and pop_ret together -> top=8'h40, wskaznik=2. A following pop exposes 8'h10.
- Assert rst mid-sequence with 3 entries -> outputs go to 0 before the next edge and pusty=1. Repeat with ID_rst -> cleared after one edge.
